// File: rtl/simple_uart_8n1.sv
// 8N1 full-duplex UART: LSB first, idle-high line, baud timing from integer clock division.
// RX and TX are independent two-process FSMs; every output is driven from a register.
module simple_uart_8n1 #(
    parameter int unsigned SYSTEM_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic       clock,
    input  logic       arst_n,
    input  logic       rx_bit,
    output logic       tx_bit,
    output logic [7:0] rx_value,
    output logic       rx_value_ready,
    input  logic [7:0] tx_value,
    input  logic       tx_value_write,
    output logic       tx_busy
);

    localparam int unsigned BIT_CYCLES  = SYSTEM_FREQ / BAUD_RATE;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_value_q, rx_value_d;
    logic             rx_ready_q, rx_ready_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_busy_q, tx_busy_d;

    // Two-flop synchronizer, preset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_bit;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX state register.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_value_q <= 8'h00;
            rx_ready_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_value_q <= rx_value_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // RX next state: centre sampling; RX_WAIT holds off re-arming after a framing error until the line is high.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_value_d = rx_value_q;
        rx_ready_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    rx_state_d = (rx_idx_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    if (rx_sync_q) begin
                        rx_value_d = rx_shift_q;
                        rx_ready_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_WAIT: begin
                rx_cnt_d   = CNT_ZERO;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
            end
            default: begin
                rx_cnt_d   = CNT_ZERO;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // TX state register; tx_bit resets to the idle-high level.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_bit_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // TX next state: the line level for the next bit is computed one cycle ahead so tx_bit stays registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_ONE;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = CNT_ZERO;
                if (tx_value_write) begin
                    tx_shift_d = tx_value;
                    tx_bit_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end else begin
                    tx_bit_d   = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_idx_d   = 3'd0;
                    tx_bit_d   = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_idx_q == 3'd7) begin
                        tx_bit_d   = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_bit_d   = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_cnt_d   = CNT_ZERO;
                tx_bit_d   = 1'b1;
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign tx_bit         = tx_bit_q;
    assign tx_busy        = tx_busy_q;
    assign rx_value       = rx_value_q;
    assign rx_value_ready = rx_ready_q;

endmodule

// File: tb/tb_simple_uart_8n1.sv
// Directed/random bench for simple_uart_8n1 at a reduced 16-cycle bit time.
module tb_simple_uart_8n1;

    localparam int unsigned SYS_F = 1_600_000;
    localparam int unsigned BAUD  = 100_000;
    localparam int BIT = 16;

    logic       clock = 1'b0;
    logic       arst_n = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx_bit;
    logic [7:0] rx_value;
    logic       rx_value_ready;
    logic [7:0] tx_value = 8'h00;
    logic       tx_value_write = 1'b0;
    logic       tx_busy;

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_rx = 8'h00;

    assign rx_line = loop_en ? tx_bit : rx_drv;

    simple_uart_8n1 #(.SYSTEM_FREQ(SYS_F), .BAUD_RATE(BAUD)) dut (
        .clock(clock), .arst_n(arst_n), .rx_bit(rx_line), .tx_bit(tx_bit),
        .rx_value(rx_value), .rx_value_ready(rx_value_ready),
        .tx_value(tx_value), .tx_value_write(tx_value_write), .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_value_ready === 1'b1) got_q.push_back(rx_value);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic tx_send(input logic [7:0] b, input int dup_at);
        tx_value = b;
        tx_value_write = 1'b1;
        tick(1);
        tx_value_write = 1'b0;
        for (int c = 0; c < 10*BIT; c++) begin
            chk("tx_bit", {31'd0, tx_bit}, {31'd0, frame_bit(b, c / BIT)});
            chk("tx_busy", {31'd0, tx_busy}, 32'd1);
            if (c == dup_at) begin
                tx_value = ~b;
                tx_value_write = 1'b1;
            end else begin
                tx_value_write = 1'b0;
            end
            tick(1);
        end
        tx_value_write = 1'b0;
        chk("tx_idle_bit", {31'd0, tx_bit}, 32'd1);
        chk("tx_busy_fall", {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 9) ? stop : frame_bit(b, k);
            tick(BIT);
        end
        rx_drv = 1'b1;
        if (stop) begin
            exp_q.push_back(b);
            last_rx = b;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_value"}, {24'd0, rx_value}, {24'd0, last_rx});
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] tb;
        #2 arst_n = 1'b0;
        tick(5);
        chk("rst_tx_bit", {31'd0, tx_bit}, 32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rx_value", {24'd0, rx_value}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_value_ready}, 32'd0);
        arst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("idle_tx_bit", {31'd0, tx_bit}, 32'd1);
            chk("idle_ready", {31'd0, rx_value_ready}, 32'd0);
            tick(1);
        end

        tx_send(8'h55, -1);
        tick(3);

        rx_frame(8'hA5, 1'b1);
        tick(2*BIT);
        check_rx("rx_a5");

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rx_frame(rb, 1'b1);
        end
        tick(2*BIT);
        check_rx("rx_rand_b2b");

        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(3*BIT);
        check_rx("rx_glitch");

        rb = 8'($urandom);
        rx_frame(rb, 1'b0);
        tick(2*BIT);
        check_rx("rx_framing");
        rb = 8'($urandom);
        rx_frame(rb, 1'b1);
        tick(2*BIT);
        check_rx("rx_recover");

        tx_send(8'h3A, 2*BIT + 5);
        tick(2*BIT);
        chk("dup_write_idle", {31'd0, tx_busy}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            tx_send(8'($urandom), -1);
            tick($urandom_range(0, 5));
        end

        rb = 8'($urandom);
        tb = 8'($urandom);
        fork
            rx_frame(rb, 1'b1);
            tx_send(tb, -1);
        join
        tick(2*BIT);
        check_rx("rx_during_tx");

        loop_en = 1'b1;
        tick(2);
        tx_send(8'h00, -1);
        tx_send(8'hFF, -1);
        tx_send(8'h3C, -1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        last_rx = 8'h3C;
        tick(2*BIT);
        check_rx("loopback");
        loop_en = 1'b0;
        tick(2);

        tx_value = 8'hF0;
        tx_value_write = 1'b1;
        tick(1);
        tx_value_write = 1'b0;
        tick(4*BIT + 3);
        chk("pre_rst_data3", {31'd0, tx_bit}, 32'd0);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_tx_bit", {31'd0, tx_bit}, 32'd1);
        chk("mid_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_rst_rx_value", {24'd0, rx_value}, 32'd0);
        last_rx = 8'h00;
        tick(5);
        arst_n = 1'b1;
        tick(2);
        tx_send(8'($urandom), -1);
        tick(2*BIT);
        check_rx("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
